// File: rtl/plru_pkg.sv
// Tree pseudo-LRU encoding shared by the state array and the eviction_LRU victim selector.
// Node 0 is the root; a node value of 0 points right (way bit 1), 1 points left (way bit 0).
package plru_pkg;

    localparam int PLRU_MAX_WAY_W = 6;
    localparam int PLRU_MAX_NODES = (1 << PLRU_MAX_WAY_W) - 1;

    typedef logic [PLRU_MAX_WAY_W-1:0] plru_way_t;
    typedef logic [PLRU_MAX_WAY_W-1:0] plru_node_t;
    typedef logic [PLRU_MAX_NODES-1:0] plru_nodes_t;

    typedef enum logic {
        OP_TOUCH = 1'b0,
        OP_INVAL = 1'b1
    } plru_op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } plru_state_e;

    // Heap index of the node visited at 'level' on the walk towards 'way'.
    function automatic plru_node_t plru_path_node(input plru_way_t way, input int level,
                                                  input int way_w);
        plru_node_t n;
        plru_way_t  w;
        n = '0;
        w = way << (PLRU_MAX_WAY_W - way_w);
        for (int l = 0; l < PLRU_MAX_WAY_W; l++) begin
            if (l < level && l < way_w) begin
                n = (n << 1) + (w[PLRU_MAX_WAY_W-1] ? plru_node_t'(2) : plru_node_t'(1));
                w = w << 1;
            end
        end
        return n;
    endfunction

    function automatic plru_nodes_t plru_update(input plru_nodes_t bits, input plru_way_t way,
                                                input plru_op_e op, input int way_w);
        plru_nodes_t nb;
        plru_way_t   w;
        nb = bits;
        w  = way << (PLRU_MAX_WAY_W - way_w);
        for (int l = 0; l < PLRU_MAX_WAY_W; l++) begin
            if (l < way_w) begin
                nb[plru_path_node(way, l, way_w)] = (op == OP_TOUCH) ? w[PLRU_MAX_WAY_W-1]
                                                                     : ~w[PLRU_MAX_WAY_W-1];
                w = w << 1;
            end
        end
        return nb;
    endfunction

endpackage

// File: rtl/plru_state_array_if.sv
// Update request port and victim lookup port between cache controller and PLRU state array.
interface plru_state_array_if
    import plru_pkg::*;
#(
    parameter int ASSOC    = 8,
    parameter int NUM_SETS = 64
);
    localparam int WAY_W = $clog2(ASSOC);
    localparam int SET_W = $clog2(NUM_SETS);

    logic             req_valid;
    logic             req_ready;
    plru_op_e         req_op;
    logic [SET_W-1:0] req_set;
    logic [WAY_W-1:0] req_way;
    logic             lookup_valid;
    logic [SET_W-1:0] lookup_set;
    logic             lookup_bits_valid;
    logic [ASSOC-2:0] lookup_bits;
    logic             init_done;

    modport master (
        output req_valid, req_op, req_set, req_way, lookup_valid, lookup_set,
        input  req_ready, lookup_bits_valid, lookup_bits, init_done
    );

    modport slave (
        input  req_valid, req_op, req_set, req_way, lookup_valid, lookup_set,
        output req_ready, lookup_bits_valid, lookup_bits, init_done
    );

endinterface

// File: rtl/plru_state_array.sv
// Per-set PLRU bit storage with a one-deep read-modify-write update stage and
// forwarded victim lookups; clears every set with a sweep after reset.
module plru_state_array
    import plru_pkg::*;
#(
    parameter int ASSOC    = 8,
    parameter int NUM_SETS = 64
) (
    input  logic clk,
    input  logic rst_n,
    plru_state_array_if.slave bus
);
    localparam int WAY_W = $clog2(ASSOC);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int NODES = ASSOC - 1;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    plru_state_e      r_state;
    plru_state_e      w_state_next;
    logic [SET_W-1:0] r_cnt;
    logic [SET_W-1:0] w_cnt_next;

    logic             r_stg_valid;
    logic [SET_W-1:0] r_stg_set;
    logic [WAY_W-1:0] r_stg_way;
    plru_op_e         r_stg_op;

    logic [NODES-1:0] r_mem [NUM_SETS];
    logic [NODES-1:0] w_stg_new;
    logic             w_accept;
    logic             r_lk_valid;
    logic [NODES-1:0] r_lk_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_next = r_cnt + SET_W'(1);
                if (r_cnt == LAST_SET) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    assign bus.req_ready = (r_state == ST_RUN);
    assign bus.init_done = (r_state == ST_RUN);
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stg_valid <= 1'b0;
        end else begin
            r_stg_valid <= w_accept;
            if (w_accept) begin
                r_stg_set <= bus.req_set;
                r_stg_way <= bus.req_way;
                r_stg_op  <= bus.req_op;
            end
        end
    end

    // The stage reads the set it is about to write, so the next request sees the result.
    assign w_stg_new = NODES'(plru_update(PLRU_MAX_NODES'(r_mem[r_stg_set]),
                                          PLRU_MAX_WAY_W'(r_stg_way), r_stg_op, WAY_W));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (r_stg_valid) begin
                r_mem[r_stg_set] <= w_stg_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lk_valid <= 1'b0;
            r_lk_bits  <= '0;
        end else begin
            r_lk_valid <= bus.lookup_valid;
            if (bus.lookup_valid) begin
                if (r_state == ST_INIT) begin
                    r_lk_bits <= '0;
                end else if (r_stg_valid && (r_stg_set == bus.lookup_set)) begin
                    r_lk_bits <= w_stg_new;
                end else begin
                    r_lk_bits <= r_mem[bus.lookup_set];
                end
            end
        end
    end

    assign bus.lookup_bits_valid = r_lk_valid;
    assign bus.lookup_bits       = r_lk_bits;

endmodule

// File: tb/tb_plru_state_array.sv
// Directed and random checks of plru_state_array: expected lookup results are queued
// when the lookup is driven and compared when the registered result appears.
module tb_plru_state_array;
    import plru_pkg::*;

    localparam int ASSOC    = 8;
    localparam int NUM_SETS = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    plru_state_array_if #(.ASSOC(ASSOC), .NUM_SETS(NUM_SETS)) bus ();

    plru_state_array #(.ASSOC(ASSOC), .NUM_SETS(NUM_SETS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [6:0] model [NUM_SETS];
    logic [6:0] exp_q [$];
    logic [6:0] last_exp = '0;
    bit         lv_sent  = 1'b0;

    // Reference walk: level l uses way bit (2-l); TOUCH stores the bit, INVAL its inverse.
    function automatic logic [6:0] m_update(input logic [6:0] bits, input int way, input bit inval);
        logic [6:0] r;
        int node;
        r    = bits;
        node = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            bit b;
            b = bit'((way >> (2 - lvl)) & 1);
            r[node[2:0]] = inval ? ~b : b;
            node = b ? 2 * node + 2 : 2 * node + 1;
        end
        return r;
    endfunction

    function automatic int victim(input logic [6:0] bits);
        int n;
        int w;
        n = 0;
        w = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            if (bits[n[2:0]]) begin
                w = w * 2;
                n = 2 * n + 1;
            end else begin
                w = w * 2 + 1;
                n = 2 * n + 2;
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (lv_sent) begin
            last_exp = exp_q.pop_front();
            chk("lk_valid", 32'(bus.lookup_bits_valid), 32'd1);
            chk("lk_bits", 32'(bus.lookup_bits), 32'(last_exp));
            $display("lookup: bits=%02h expected=%02h", bus.lookup_bits, last_exp);
        end else begin
            chk("lk_valid_low", 32'(bus.lookup_bits_valid), 32'd0);
            chk("lk_bits_hold", 32'(bus.lookup_bits), 32'(last_exp));
        end
    endtask

    // exp_ovr >= 0 forces a literal expected lookup value instead of the model's.
    task automatic do_cycle(input bit rv, input bit inval, input int set, input int way,
                            input bit lv, input int lset, input int exp_ovr);
        bus.req_valid    = rv;
        bus.req_op       = inval ? OP_INVAL : OP_TOUCH;
        bus.req_set      = 6'(set);
        bus.req_way      = 3'(way);
        bus.lookup_valid = lv;
        bus.lookup_set   = 6'(lset);
        if (lv) exp_q.push_back(exp_ovr >= 0 ? 7'(exp_ovr) : model[lset]);
        if (rv && bus.req_ready) model[set] = m_update(model[set], way, inval);
        lv_sent = lv;
        tick();
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, -1);
    endtask

    task automatic do_reset(input int edges);
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.lookup_valid = 1'b0;
        lv_sent          = 1'b0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_init_done", 32'(bus.init_done), 32'd0);
            chk("rst_lk_valid", 32'(bus.lookup_bits_valid), 32'd0);
            chk("rst_lk_bits", 32'(bus.lookup_bits), 32'd0);
        end
        for (int s = 0; s < NUM_SETS; s++) model[s] = '0;
        exp_q.delete();
        last_exp = '0;
        rst_n    = 1'b1;
        $display("reset: %0d edge(s), released", edges);
    endtask

    // Ready must stay low for NUM_SETS cycles after release; a request and a lookup
    // issued mid-sweep must be ignored and return zero respectively.
    task automatic sweep_check(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            if (k == 10) do_cycle(1'b1, 1'b0, 5, 0, 1'b1, 5, 0);
            else idle();
            chk("sweep_ready", 32'(bus.req_ready), 32'(k >= NUM_SETS - 1));
            chk("sweep_init_done", 32'(bus.init_done), 32'(k >= NUM_SETS - 1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_op       = OP_TOUCH;
        bus.req_set      = '0;
        bus.req_way      = '0;
        bus.lookup_valid = 1'b0;
        bus.lookup_set   = '0;
        for (int s = 0; s < NUM_SETS; s++) model[s] = '0;

        do_reset(3);
        sweep_check(NUM_SETS);

        do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 5, 'h00);
        chk("victim_cleared", 32'(victim(bus.lookup_bits)), 32'd7);

        do_cycle(1'b1, 1'b0, 3, 7, 1'b1, 3, 'h00);
        do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 3, 'h45);
        chk("victim_touch7", 32'(victim(bus.lookup_bits)), 32'd3);
        idle();
        do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 3, 'h45);

        do_cycle(1'b1, 1'b0, 3, 7, 1'b0, 0, -1);
        do_cycle(1'b1, 1'b0, 3, 3, 1'b1, 3, 'h45);
        do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 3, 'h56);
        chk("victim_b2b", 32'(victim(bus.lookup_bits)), 32'd5);

        do_cycle(1'b1, 1'b1, 9, 2, 1'b0, 0, -1);
        do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 9, 'h11);
        chk("victim_inval", 32'(victim(bus.lookup_bits)), 32'd2);
        do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 9, 'h11);

        for (int i = 0; i < 10000; i++) begin
            bit rv, inval, lv;
            int set, way, lset;
            rv    = ($urandom_range(0, 3) != 0);
            inval = bit'($urandom_range(0, 1));
            set   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
            way   = int'($urandom_range(0, 7));
            lv    = bit'($urandom_range(0, 1));
            lset  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
            do_cycle(rv, inval, set, way, lv, lset, -1);
        end

        do_cycle(1'b1, 1'b0, 1, 7, 1'b0, 0, -1);
        do_reset(1);
        sweep_check(20);
        do_reset(1);
        sweep_check(NUM_SETS);
        for (int s = 0; s < NUM_SETS; s++) do_cycle(1'b0, 1'b0, 0, 0, 1'b1, s, 'h00);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
